// File: rtl/ifu_def.sv
// Shared fetch-unit definitions: sequencer FSM states, reset PC and the PC source-select
// encoding, which npc-side debug also decodes.
package ifu_def;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PCSEL_EXC   = 2'd0,
    PCSEL_FLUSH = 2'd1,
    PCSEL_PRED  = 2'd2,
    PCSEL_SEQ   = 2'd3
  } pc_sel_e;

  // An odd-word PC fetches a single word to realign; an aligned PC fetches a pair.
  function automatic logic [31:0] seq_next_pc(input logic [31:0] cur_pc);
    return cur_pc[2] ? cur_pc + 32'd4 : cur_pc + 32'd8;
  endfunction

endpackage

// File: rtl/fetch_inflight_tracker.sv
// Counts in-flight fetches and stale responses still owed from before the last redirect;
// decides whether the current response goes to decode or is discarded.
module fetch_inflight_tracker #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_accept,
  input  logic i_resp_valid,
  input  logic i_redirect,
  output logic o_room,
  output logic o_resp_accept,
  output logic o_resp_drop,
  output logic o_drop_pending_next
);

  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] w_drop_cnt_next;
  logic             w_resp_legal;
  logic             w_drop;

  // A response with nothing in flight is a protocol violation and is ignored entirely.
  assign w_resp_legal = i_resp_valid & (r_outstanding != '0);
  assign w_drop       = w_resp_legal & ((r_drop_cnt != '0) | i_redirect);

  assign o_room              = r_outstanding < CNT_W'(MAX_OUTSTANDING);
  assign o_resp_drop         = w_drop;
  assign o_resp_accept       = w_resp_legal & ~w_drop;
  assign o_drop_pending_next = w_drop_cnt_next != '0;

  // Every request still in flight at a redirect belongs to the abandoned path.
  always_comb begin
    w_drop_cnt_next = r_drop_cnt;
    if (i_redirect)
      w_drop_cnt_next = r_outstanding - CNT_W'(w_resp_legal);
    else if (w_drop)
      w_drop_cnt_next = r_drop_cnt - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      assert (!(i_resp_valid && r_outstanding == '0));
      r_outstanding <= r_outstanding + CNT_W'(i_accept) - CNT_W'(w_resp_legal);
      r_drop_cnt    <= w_drop_cnt_next;
    end
  end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC register and request sequencer: exception > flush > predictor > sequential,
// with one bubble per redirect and stale responses discarded until the old path drains.
module fetch_pc_sequencer
  import ifu_def::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          CNT_W           = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  input  logic        flush_valid,
  input  logic [31:0] flush_pc,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  output logic        fetch_req_valid,
  output logic [31:0] fetch_req_pc,
  input  logic        fetch_req_ready,
  input  logic        fetch_resp_valid,
  output logic        resp_accept,
  output logic        resp_drop,
  output logic [31:0] pc,
  output logic [31:0] redirect_cnt,
  output logic [31:0] drop_total
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_redirect_cnt;
  logic [31:0]  r_drop_total;
  pc_sel_e      w_sel;
  logic [31:0]  w_pc_next;
  logic         w_redirect;
  logic         w_accept;
  logic         w_room;
  logic         w_drop_pending_next;

  assign w_redirect      = exc_valid | flush_valid;
  assign fetch_req_valid = (r_state != ST_BOOT) & ~stall & ~w_redirect & w_room;
  assign w_accept        = fetch_req_valid & fetch_req_ready;
  assign fetch_req_pc    = r_pc;
  assign pc              = r_pc;
  assign redirect_cnt    = r_redirect_cnt;
  assign drop_total      = r_drop_total;

  fetch_inflight_tracker #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_tracker (
    .clk                 (clk),
    .rst                 (rst),
    .i_accept            (w_accept),
    .i_resp_valid        (fetch_resp_valid),
    .i_redirect          (w_redirect),
    .o_room              (w_room),
    .o_resp_accept       (resp_accept),
    .o_resp_drop         (resp_drop),
    .o_drop_pending_next (w_drop_pending_next)
  );

  always_comb begin
    w_sel = PCSEL_SEQ;
    if (exc_valid)        w_sel = PCSEL_EXC;
    else if (flush_valid) w_sel = PCSEL_FLUSH;
    else if (pred_valid)  w_sel = PCSEL_PRED;
  end

  always_comb begin
    case (w_sel)
      PCSEL_EXC:   w_pc_next = exc_pc;
      PCSEL_FLUSH: w_pc_next = flush_pc;
      PCSEL_PRED:  w_pc_next = pred_pc;
      default:     w_pc_next = seq_next_pc(r_pc);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_BOOT;
      r_pc           <= RESET_PC;
      r_redirect_cnt <= '0;
      r_drop_total   <= '0;
    end else begin
      if (w_redirect | w_accept) r_pc <= w_pc_next;
      if (w_redirect)            r_redirect_cnt <= r_redirect_cnt + 32'd1;
      if (resp_drop)             r_drop_total <= r_drop_total + 32'd1;
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        default: r_state <= w_drop_pending_next ? ST_DRAIN : ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Drives fetch_pc_sequencer with directed scenarios and random traffic; expectations come
// from an epoch-tagged queue model of the in-flight requests.
module tb_fetch_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, exc_valid, flush_valid, pred_valid;
  logic [31:0] exc_pc, flush_pc, pred_pc;
  logic        fetch_req_valid, fetch_req_ready, fetch_resp_valid;
  logic [31:0] fetch_req_pc, pc, redirect_cnt, drop_total;
  logic        resp_accept, resp_drop;

  always #5 clk = ~clk;

  fetch_pc_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .exc_valid        (exc_valid),
    .exc_pc           (exc_pc),
    .flush_valid      (flush_valid),
    .flush_pc         (flush_pc),
    .pred_valid       (pred_valid),
    .pred_pc          (pred_pc),
    .fetch_req_valid  (fetch_req_valid),
    .fetch_req_pc     (fetch_req_pc),
    .fetch_req_ready  (fetch_req_ready),
    .fetch_resp_valid (fetch_resp_valid),
    .resp_accept      (resp_accept),
    .resp_drop        (resp_drop),
    .pc               (pc),
    .redirect_cnt     (redirect_cnt),
    .drop_total       (drop_total)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: each in-flight request carries the epoch it was issued in; a redirect starts a
  // new epoch, so a response is stale exactly when its epoch is not the current one.
  logic [31:0] m_pc, n_pc, m_redir, n_redir, m_drops, n_drops;
  bit          m_boot, n_boot;
  int          m_q[$], n_q[$];
  int          m_epoch, n_epoch;
  bit          e_vld, e_acc, e_drop;

  task automatic step(input bit s, input bit ex, input logic [31:0] epc, input bit fl,
                      input logic [31:0] fpc, input bit pv, input logic [31:0] ppc,
                      input bit rdy, input bit rsp);
    bit redir;
    @(posedge clk);
    #1;
    m_pc = n_pc; m_boot = n_boot; m_q = n_q; m_epoch = n_epoch;
    m_redir = n_redir; m_drops = n_drops;
    if (m_q.size() == 0) rsp = 1'b0;
    stall = s; exc_valid = ex; exc_pc = epc; flush_valid = fl; flush_pc = fpc;
    pred_valid = pv; pred_pc = ppc; fetch_req_ready = rdy; fetch_resp_valid = rsp;
    redir  = ex | fl;
    e_vld  = !m_boot && !s && !redir && (m_q.size() < 4);
    e_drop = rsp && (redir || m_q[0] != m_epoch);
    e_acc  = rsp && !e_drop;
    n_pc = m_pc; n_q = m_q; n_epoch = m_epoch; n_redir = m_redir; n_drops = m_drops;
    n_boot = 1'b0;
    if (rsp)    void'(n_q.pop_front());
    if (e_drop) n_drops = n_drops + 32'd1;
    if (redir) begin
      n_epoch = m_epoch + 1;
      n_redir = m_redir + 32'd1;
      n_pc    = ex ? epc : fpc;
    end else if (e_vld && rdy) begin
      n_q.push_back(m_epoch);
      n_pc = pv ? ppc : m_pc + (m_pc[2] ? 32'd4 : 32'd8);
    end
    #3;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 0; exc_valid = 0; flush_valid = 0; pred_valid = 0;
    exc_pc = 0; flush_pc = 0; pred_pc = 0; fetch_req_ready = 0; fetch_resp_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #3;
    n_cmp++;
    if (pc !== 32'hBFC0_0000 || fetch_req_valid !== 1'b0 || resp_accept !== 1'b0 ||
        resp_drop !== 1'b0 || redirect_cnt !== 32'd0 || drop_total !== 32'd0) begin
      n_bad++;
      $display("FAIL reset: pc=%h vld=%b acc=%b drop=%b rc=%0d dt=%0d required pc=bfc00000 all zero",
               pc, fetch_req_valid, resp_accept, resp_drop, redirect_cnt, drop_total);
    end
    m_pc = 32'hBFC0_0000; m_boot = 1; m_q.delete(); m_epoch = 0; m_redir = 0; m_drops = 0;
    n_pc = m_pc; n_boot = 0; n_q.delete(); n_epoch = 0; n_redir = 0; n_drops = 0;
  endtask

  task automatic drain_all();
    for (int i = 0; i < 20 && n_q.size() > 0; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      n_cmp++;
      if (resp_accept !== e_acc || resp_drop !== e_drop || fetch_req_valid !== e_vld) begin
        n_bad++;
        $display("FAIL drain: acc=%b drop=%b vld=%b required acc=%b drop=%b vld=%b",
                 resp_accept, resp_drop, fetch_req_valid, e_acc, e_drop, e_vld);
      end
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 1, i >= 1);
      n_cmp++;
      if (fetch_req_valid !== e_vld || pc !== m_pc || fetch_req_pc !== m_pc ||
          resp_accept !== e_acc || resp_drop !== e_drop) begin
        n_bad++;
        $display("FAIL seq c%0d: vld=%b pc=%h acc=%b drop=%b required vld=%b pc=%h acc=%b drop=%b",
                 i, fetch_req_valid, pc, resp_accept, resp_drop, e_vld, m_pc, e_acc, e_drop);
      end
      if (i == 2) begin
        n_cmp++;
        if (pc !== 32'hBFC0_0010) begin
          n_bad++;
          $display("FAIL seq_pc2: pc=%h required bfc00010", pc);
        end
      end
    end
    drain_all();
  endtask

  task automatic test_pred();
    logic [31:0] want [4];
    want[0] = 32'h8000_0004; want[1] = 32'h8000_0008; want[2] = 32'h8000_1000;
    want[3] = 32'h8000_1008;
    step(0, 1, 32'h8000_0004, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, i == 1, 32'h8000_1000, 1, 0);
      n_cmp++;
      if (pc !== want[i] || pc !== m_pc || fetch_req_valid !== e_vld) begin
        n_bad++;
        $display("FAIL pred c%0d: pc=%h vld=%b required pc=%h vld=%b", i, pc, fetch_req_valid,
                 want[i], e_vld);
      end
    end
    drain_all();
  endtask

  task automatic test_flush_drain();
    logic [31:0] d0, r0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    d0 = m_drops; r0 = m_redir;
    step(0, 0, 0, 1, 32'h8000_2000, 0, 0, 1, 0);
    n_cmp++;
    if (fetch_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_bubble: vld=%b required 0", fetch_req_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, i == 0, 1);
      n_cmp++;
      if (resp_drop !== (i < 3) || resp_accept !== (i == 3) || resp_drop !== e_drop ||
          pc !== m_pc) begin
        n_bad++;
        $display("FAIL flush_resp%0d: drop=%b acc=%b pc=%h required drop=%b acc=%b pc=%h",
                 i, resp_drop, resp_accept, pc, i < 3, i == 3, m_pc);
      end
    end
    n_cmp++;
    if (drop_total !== d0 + 32'd3 || redirect_cnt !== r0 + 32'd1) begin
      n_bad++;
      $display("FAIL flush_counters: dt=%0d rc=%0d required dt=%0d rc=%0d", drop_total,
               redirect_cnt, d0 + 32'd3, r0 + 32'd1);
    end
    drain_all();
  endtask

  task automatic test_exc_flush();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 32'h9000_0000, 1, 32'h8000_3000, 0, 0, 1, 1);
    n_cmp++;
    if (resp_drop !== 1'b1 || resp_accept !== 1'b0 || fetch_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL excflush_resp: drop=%b acc=%b vld=%b required 1 0 0", resp_drop,
               resp_accept, fetch_req_valid);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    n_cmp++;
    if (pc !== 32'h9000_0000 || resp_drop !== 1'b1) begin
      n_bad++;
      $display("FAIL excflush_pc: pc=%h drop=%b required pc=90000000 drop=1", pc, resp_drop);
    end
    step(0, 0, 0, 1, 32'h8000_4000, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, i == 0, 1);
      n_cmp++;
      if (resp_drop !== e_drop || resp_accept !== e_acc || pc !== m_pc ||
          fetch_req_valid !== e_vld) begin
        n_bad++;
        $display("FAIL drain_reflush%0d: drop=%b acc=%b pc=%h required drop=%b acc=%b pc=%h",
                 i, resp_drop, resp_accept, pc, e_drop, e_acc, m_pc);
      end
    end
    drain_all();
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    held = n_pc;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (fetch_req_valid !== 1'b0 || pc !== held) begin
        n_bad++;
        $display("FAIL full_hold%0d: vld=%b pc=%h required vld=0 pc=%h", i, fetch_req_valid,
                 pc, held);
      end
    end
    drain_all();
    held = n_pc;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 1, 32'h1234_5678, 1, 0);
      n_cmp++;
      if (fetch_req_valid !== 1'b0 || pc !== held) begin
        n_bad++;
        $display("FAIL stall_hold%0d: vld=%b pc=%h required vld=0 pc=%h", i, fetch_req_valid,
                 pc, held);
      end
    end
    step(1, 0, 0, 1, 32'h8000_5000, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    n_cmp++;
    if (pc !== 32'h8000_5000 || fetch_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_redirect: pc=%h vld=%b required pc=80005000 vld=0", pc,
               fetch_req_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      step($urandom % 5 == 0, $urandom % 23 == 0, $urandom, $urandom % 11 == 0, $urandom,
           $urandom % 4 == 0, $urandom, $urandom % 3 != 0, $urandom % 2 == 0);
      n_cmp++;
      if (fetch_req_valid !== e_vld || pc !== m_pc || fetch_req_pc !== m_pc ||
          resp_accept !== e_acc || resp_drop !== e_drop || redirect_cnt !== m_redir ||
          drop_total !== m_drops) begin
        n_bad++;
        $display("FAIL random c%0d: vld=%b pc=%h acc=%b drop=%b rc=%0d dt=%0d required vld=%b pc=%h acc=%b drop=%b rc=%0d dt=%0d",
                 i, fetch_req_valid, pc, resp_accept, resp_drop, redirect_cnt, drop_total,
                 e_vld, m_pc, e_acc, e_drop, m_redir, m_drops);
      end
    end
    drain_all();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_pred();
    test_flush_drain();
    test_exc_flush();
    test_backpressure();
    test_random();
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    test_reset();
    test_sequential();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
